idma_desc64_submit: RTL and testbench

// - APB initiator feeding descriptor pointers into the desc64 frontend's APB register file.
// - Buffers 64-bit descriptor addresses from a local producer (core or sequencer) in a FIFO.
// - Writes each address to the frontend's descriptor-address register; optionally polls its status first.
// - Sits beside the desc64 frontend and drives its apb slave port directly.

---
 rtl/idma_desc64_submit_pkg.sv | 44 ++++
 rtl/idma_desc64_submit_fifo.sv | 76 +++++++
 rtl/idma_desc64_submit.sv | 173 +++++++++++++++++
 tb/tb_idma_desc64_submit.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idma_desc64_submit_pkg.sv
// Shared types and constants for the desc64 submit initiator.
// The optional status poll before each write is enabled by defining
// IDMA_DESC64_SUBMIT_POLL_EN.
package idma_desc64_submit_pkg;

  // Default APB register map of the desc64 frontend.
  localparam logic [31:0] DefaultDescAddrOffset = 32'h10;
  localparam logic [31:0] DefaultStatusOffset   = 32'h8;
  // Bit of the status register that reports "input FIFO full".
  localparam int unsigned StatusFullBit = 1;

  // FSM state encodings.
  localparam logic [2:0] StIdle       = 3'd0;
  localparam logic [2:0] StPollSetup  = 3'd1;
  localparam logic [2:0] StPollAccess = 3'd2;
  localparam logic [2:0] StWrSetup    = 3'd3;
  localparam logic [2:0] StWrAccess   = 3'd4;

  typedef enum logic [2:0] {
    IDLE        = StIdle,
    POLL_SETUP  = StPollSetup,
    POLL_ACCESS = StPollAccess,
    WR_SETUP    = StWrSetup,
    WR_ACCESS   = StWrAccess
  } state_e;

  // Default APB request/response types (32-bit address, 64-bit data).
  typedef struct packed {
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [63:0] pwdata;
    logic [7:0]  pstrb;
  } apb_req_std_t;

  typedef struct packed {
    logic        pready;
    logic [63:0] prdata;
    logic        pslverr;
  } apb_rsp_std_t;

endpackage

// File: rtl/idma_desc64_submit_fifo.sv
// Small synchronous FIFO with the fifo_v3 parameter set (FALL_THROUGH, DEPTH,
// DATA_WIDTH). Push when full and pop when empty are ignored.
module idma_desc64_submit_fifo #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned DATA_WIDTH   = 64,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CntW-1:0]       usage_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  bypass;
  logic                  do_push;
  logic                  do_pop;

  // In fall-through mode an entry pushed and popped while empty never lands.
  assign bypass  = FALL_THROUGH && (cnt_q == '0) && push_i && pop_i;
  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0) && !(FALL_THROUGH && push_i);
  assign usage_o = cnt_q;
  assign do_push = push_i && !full_o && !bypass;
  assign do_pop  = pop_i && (cnt_q != '0) && !bypass;
  assign data_o  = (FALL_THROUGH && (cnt_q == '0)) ? data_i : mem_q[rd_ptr_q];

  // Pointer and occupancy next-state, wrapping pointers at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents are meaningless while the count says empty.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/idma_desc64_submit.sv
// APB initiator that writes buffered descriptor pointers into the desc64
// frontend's descriptor-address register. Define IDMA_DESC64_SUBMIT_POLL_EN
// to read the frontend status register before every write and only write
// once it reports not-full.
//
// Handshake: a producer pointer is accepted on any clock edge where
// desc_valid_i && desc_ready_o; desc_ready_o depends only on FIFO fullness
// (and reset), never on desc_valid_i. On APB, psel/paddr/pwrite/pwdata are
// held from the setup cycle through the access cycle in which pready is 1.
module idma_desc64_submit
  import idma_desc64_submit_pkg::*;
#(
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned FifoDepth      = 4,
  parameter logic [31:0] DescAddrOffset = DefaultDescAddrOffset,
  parameter logic [31:0] StatusOffset   = DefaultStatusOffset,
  parameter type         apb_req_t      = apb_req_std_t,
  parameter type         apb_rsp_t      = apb_rsp_std_t
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [AddrWidth-1:0] desc_addr_i,
  input  logic                 desc_valid_i,
  output logic                 desc_ready_o,
  output apb_req_t             apb_req_o,
  input  apb_rsp_t             apb_rsp_i,
  output logic                 busy_o,
  output logic [31:0]          submitted_o,
  output logic                 error_o,
  output logic [2:0]           state_o
);

  localparam int unsigned UsageW = $clog2(FifoDepth + 1);

`ifdef IDMA_DESC64_SUBMIT_POLL_EN
  localparam state_e FirstSetup = POLL_SETUP;
`else
  localparam state_e FirstSetup = WR_SETUP;
`endif

  state_e              state_q, state_d;
  logic [31:0]         submitted_q, submitted_d;
  logic                error_q, error_d;
  logic                fifo_full;
  logic                fifo_empty;
  logic [UsageW-1:0]   fifo_usage;
  logic [AddrWidth-1:0] fifo_head;
  logic                fifo_push;
  logic                fifo_pop;
  logic                unused_rsp;

  // Not every response bit is consumed in every configuration.
  assign unused_rsp = ^apb_rsp_i;

  assign desc_ready_o = ~fifo_full & ~rst_i;
  assign fifo_push    = desc_valid_i & desc_ready_o;
  assign busy_o       = ~fifo_empty | (state_q != IDLE);
  assign submitted_o  = submitted_q;
  assign error_o      = error_q;
  assign state_o      = state_q;

  idma_desc64_submit_fifo #(
    .FALL_THROUGH (1'b0),
    .DEPTH        (FifoDepth),
    .DATA_WIDTH   (AddrWidth)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (desc_addr_i),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (fifo_usage)
  );

  // Transfer sequencing, FIFO pop, success counter and sticky error.
  always_comb begin
    state_d     = state_q;
    submitted_d = submitted_q;
    error_d     = error_q;
    fifo_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        // A push this cycle already starts the setup phase next cycle.
        if (!fifo_empty || fifo_push) begin
          state_d = FirstSetup;
        end
      end
`ifdef IDMA_DESC64_SUBMIT_POLL_EN
      POLL_SETUP: begin
        state_d = POLL_ACCESS;
      end
      POLL_ACCESS: begin
        if (apb_rsp_i.pready) begin
          if (apb_rsp_i.pslverr) begin
            // A failed status read is treated as not-full.
            error_d = 1'b1;
            state_d = WR_SETUP;
          end else if (apb_rsp_i.prdata[StatusFullBit]) begin
            state_d = POLL_SETUP;
          end else begin
            state_d = WR_SETUP;
          end
        end
      end
`endif
      WR_SETUP: begin
        state_d = WR_ACCESS;
      end
      WR_ACCESS: begin
        if (apb_rsp_i.pready) begin
          // The entry is dropped even on pslverr; no retry.
          fifo_pop = 1'b1;
          if (apb_rsp_i.pslverr) begin
            error_d = 1'b1;
          end else begin
            submitted_d = submitted_q + 32'd1;
          end
          if ((fifo_usage > UsageW'(1)) || fifo_push) begin
            state_d = FirstSetup;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // APB request decode from the current state; all-zero when idle.
  always_comb begin
    apb_req_o = '0;
    case (state_q)
`ifdef IDMA_DESC64_SUBMIT_POLL_EN
      POLL_SETUP, POLL_ACCESS: begin
        apb_req_o.psel    = 1'b1;
        apb_req_o.penable = (state_q == POLL_ACCESS);
        apb_req_o.pwrite  = 1'b0;
        apb_req_o.paddr   = StatusOffset;
      end
`endif
      WR_SETUP, WR_ACCESS: begin
        apb_req_o.psel    = 1'b1;
        apb_req_o.penable = (state_q == WR_ACCESS);
        apb_req_o.pwrite  = 1'b1;
        apb_req_o.paddr   = DescAddrOffset;
        apb_req_o.pwdata  = fifo_head;
        apb_req_o.pstrb   = '1;
      end
      default: begin
        apb_req_o = '0;
      end
    endcase
  end

  // State, counter and error registers; async reset returns to IDLE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      submitted_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      submitted_q <= submitted_d;
      error_q     <= error_d;
    end
  end

endmodule

// File: tb/tb_idma_desc64_submit.sv
// Directed testbench for idma_desc64_submit with an APB slave model and a
// transaction-level reference model. Poll-specific vectors run only when
// IDMA_DESC64_SUBMIT_POLL_EN is defined.
module tb_idma_desc64_submit;
  import idma_desc64_submit_pkg::*;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [63:0]  desc_addr_i;
  logic         desc_valid_i;
  logic         desc_ready_o;
  apb_req_std_t apb_req_o;
  apb_rsp_std_t apb_rsp_i;
  logic         busy_o;
  logic [31:0]  submitted_o;
  logic         error_o;
  logic [2:0]   state_o;

  always #5 clk_i = ~clk_i;

  idma_desc64_submit #(
    .AddrWidth      (64),
    .FifoDepth      (DEPTH),
    .DescAddrOffset (32'h10),
    .StatusOffset   (32'h8),
    .apb_req_t      (apb_req_std_t),
    .apb_rsp_t      (apb_rsp_std_t)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .desc_addr_i  (desc_addr_i),
    .desc_valid_i (desc_valid_i),
    .desc_ready_o (desc_ready_o),
    .apb_req_o    (apb_req_o),
    .apb_rsp_i    (apb_rsp_i),
    .busy_o       (busy_o),
    .submitted_o  (submitted_o),
    .error_o      (error_o),
    .state_o      (state_o)
  );

  // ---------------- scoreboard / model state ----------------
  logic [63:0] stim_q[$];   // pointers the producer still has to offer
  logic [63:0] exp_q[$];    // pointers accepted, in expected write order
  logic [63:0] wr_log[$];   // pointers actually written on APB
  int          occ;         // accepted but not yet written
  logic [31:0] m_sub;
  logic        m_err;
  logic        prev_push;
  logic [63:0] prev_push_data;
  logic        prev_active;
  apb_req_std_t prev_req;
  logic        poll_ok;
  // slave configuration
  int delay_cfg;
  int acc_wait;
  int err_wr_idx;
  int wr_count;
  int rd_count;
  int poll_full_left;
  int stall_cycles;
  // results
  int checks;
  int failures;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    stim_q.delete();
    exp_q.delete();
    occ         = 0;
    m_sub       = '0;
    m_err       = 1'b0;
    prev_push   = 1'b0;
    prev_active = 1'b0;
    acc_wait    = 0;
    poll_ok     = 1'b0;
  endtask

  // One cycle: account for the last edge, compare, then drive the next one.
  task automatic tick();
    apb_rsp_std_t rsp;
    apb_req_std_t held;
    @(negedge clk_i);
    if (rst_i) begin
      check("rst_req_zero", (apb_req_o == '0), 1);
      check("rst_ready", desc_ready_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_submitted", submitted_o, 0);
      check("rst_error", error_o, 0);
      desc_valid_i = 1'b0;
      desc_addr_i  = '0;
      apb_rsp_i    = '0;
      prev_push    = 1'b0;
      prev_active  = 1'b0;
      return;
    end
    // producer accepted on the last edge
    if (prev_push) begin
      occ++;
      exp_q.push_back(prev_push_data);
      void'(stim_q.pop_front());
    end
    // outputs against the model
    check("submitted", submitted_o, m_sub);
    check("error", error_o, m_err);
    check("busy", busy_o, (occ != 0));
    check("ready", desc_ready_o, (occ < DEPTH));
    check("psel_when_pending", apb_req_o.psel, (occ != 0));
    if (prev_active) begin
      held = prev_req;
      held.penable = 1'b1;
      check("apb_stable", (apb_req_o == held), 1);
    end else if (apb_req_o.psel) begin
      check("setup_penable", apb_req_o.penable, 0);
    end
    // APB slave
    rsp = '0;
    if (apb_req_o.psel && apb_req_o.penable) begin
      if (acc_wait < delay_cfg) begin
        acc_wait++;
      end else begin
        acc_wait   = 0;
        rsp.pready = 1'b1;
        if (apb_req_o.pwrite) begin
          wr_count++;
          check("wr_paddr", apb_req_o.paddr, 64'h10);
          check("wr_pstrb", apb_req_o.pstrb, 64'hFF);
          check("wr_pprot", apb_req_o.pprot, 0);
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL wr_unexpected: got write %0h expected none", apb_req_o.pwdata);
          end else if (apb_req_o.pwdata !== exp_q[0]) begin
            failures++;
            $display("FAIL wr_data: got %0h expected %0h", apb_req_o.pwdata, exp_q[0]);
            void'(exp_q.pop_front());
          end else begin
            void'(exp_q.pop_front());
          end
`ifdef IDMA_DESC64_SUBMIT_POLL_EN
          check("wr_after_not_full_poll", poll_ok, 1);
          poll_ok = 1'b0;
`endif
          wr_log.push_back(apb_req_o.pwdata);
          occ--;
          if (wr_count == err_wr_idx) begin
            rsp.pslverr = 1'b1;
            m_err = 1'b1;
          end else begin
            m_sub = m_sub + 32'd1;
          end
        end else begin
          rd_count++;
          check("rd_paddr", apb_req_o.paddr, 64'h8);
          if (poll_full_left > 0) begin
            rsp.prdata[1] = 1'b1;
            poll_full_left--;
            poll_ok = 1'b0;
          end else begin
            poll_ok = 1'b1;
          end
        end
      end
    end
    apb_rsp_i = rsp;
    // producer driver
    if (stim_q.size() > 0) begin
      desc_valid_i = 1'b1;
      desc_addr_i  = stim_q[0];
    end else begin
      desc_valid_i = 1'b0;
      desc_addr_i  = '0;
    end
    if (desc_valid_i && !desc_ready_o) stall_cycles++;
    prev_push      = desc_valid_i && desc_ready_o;
    prev_push_data = desc_addr_i;
    prev_active    = apb_req_o.psel && !(apb_req_o.penable && rsp.pready);
    prev_req       = apb_req_o;
  endtask

  // Tick until everything offered has been written, within a cycle budget.
  task automatic run(input string name, input int budget);
    bit done = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (stim_q.size() == 0 && occ == 0 && !prev_push) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got occ=%0d expected drained within %0d cycles", name, occ, budget);
    end
    tick();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    checks = 0; failures = 0;
    delay_cfg = 0; err_wr_idx = 0; wr_count = 0; rd_count = 0;
    poll_full_left = 0; stall_cycles = 0;
    model_reset();
    rst_i = 1'b1;
    desc_valid_i = 1'b0; desc_addr_i = '0; apb_rsp_i = '0;
    tick(); tick();
    rst_i = 1'b0;
    tick();

    // T1: single pointer, always-ready slave
    stim_q.push_back(64'h1000);
    run("t1", 50);
    check("t1_wr_count", wr_log.size(), 1);
    check("t1_wr_data", wr_log[0], 64'h1000);
    check("t1_submitted", submitted_o, 1);
    check("t1_busy", busy_o, 0);
    wr_log.delete();

    // T2: five back-to-back pointers, slave with 3 wait states
    delay_cfg = 3; stall_cycles = 0;
    for (int i = 0; i < 5; i++) stim_q.push_back(64'hA000 + 64'(i) * 64'h40);
    run("t2", 300);
    check("t2_wr_count", wr_log.size(), 5);
    check("t2_wr0", wr_log[0], 64'hA000);
    check("t2_wr2", wr_log[2], 64'hA080);
    check("t2_wr4", wr_log[4], 64'hA100);
    check("t2_ready_stalled", (stall_cycles > 0), 1);
    check("t2_submitted", submitted_o, 6);
    wr_log.delete();
    delay_cfg = 0;

`ifdef IDMA_DESC64_SUBMIT_POLL_EN
    // T3: frontend reports full for three polls
    rd_count = 0; poll_full_left = 3;
    stim_q.push_back(64'h3000);
    run("t3", 100);
    check("t3_reads", rd_count, 4);
    check("t3_wr_count", wr_log.size(), 1);
    check("t3_wr_data", wr_log[0], 64'h3000);
    wr_log.delete();
`else
    check("no_reads_without_poll", rd_count, 0);
`endif

    // T4: slave error on the second of three writes
    delay_cfg = 1; wr_count = 0; err_wr_idx = 2;
    stim_q.push_back(64'h4000); stim_q.push_back(64'h4008); stim_q.push_back(64'h4010);
    run("t4", 200);
    check("t4_error", error_o, 1);
`ifdef IDMA_DESC64_SUBMIT_POLL_EN
    check("t4_submitted", submitted_o, 9);
`else
    check("t4_submitted", submitted_o, 8);
`endif
    check("t4_busy", busy_o, 0);
    check("t4_wr_count", wr_log.size(), 3);
    err_wr_idx = 0;
    stim_q.push_back(64'h4018);
    run("t4b", 100);
    check("t4_error_sticky", error_o, 1);
    wr_log.delete();

    // T5: reset while a write access is stretched
    delay_cfg = 40; found = 0;
    stim_q.push_back(64'h5000);
    for (int i = 0; i < 80; i++) begin
      tick();
      if (apb_req_o.psel && apb_req_o.penable && apb_req_o.pwrite) begin
        found = 1;
        break;
      end
    end
    check("t5_reached_wr_access", found, 1);
    rst_i = 1'b1;
    #1;
    check("t5_psel_drop", apb_req_o.psel, 0);
    check("t5_busy", busy_o, 0);
    check("t5_submitted", submitted_o, 0);
    check("t5_error", error_o, 0);
    model_reset();
    tick(); tick();
    rst_i = 1'b0;
    delay_cfg = 0;
    wr_log.delete();
    stim_q.push_back(64'h6000); stim_q.push_back(64'h6008);
    run("t5b", 100);
    check("t5_post_wr_count", wr_log.size(), 2);
    check("t5_post_wr1", wr_log[1], 64'h6008);
    check("t5_post_submitted", submitted_o, 2);
    wr_log.delete();

    // T6: success counter wraps at 2^32
    force dut.submitted_q = 32'hFFFF_FFFF;
    m_sub = 32'hFFFF_FFFF;
    @(posedge clk_i);
    #1;
    release dut.submitted_q;
    tick();
    check("t6_preload", submitted_o, 64'hFFFF_FFFF);
    stim_q.push_back(64'h7000);
    run("t6", 50);
    check("t6_wrapped", submitted_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
